// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: function codes and FSM states.
package alu_arbiter_pkg;

  localparam logic [3:0] FN_ADD    = 4'b0000;
  localparam logic [3:0] FN_SUB    = 4'b1000;
  localparam logic [3:0] FN_SLL    = 4'b0001;
  localparam logic [3:0] FN_SLT    = 4'b0010;
  localparam logic [3:0] FN_SLTU   = 4'b0011;
  localparam logic [3:0] FN_XOR    = 4'b0100;
  localparam logic [3:0] FN_SRL    = 4'b0101;
  localparam logic [3:0] FN_SRA    = 4'b1101;
  localparam logic [3:0] FN_OR     = 4'b0110;
  localparam logic [3:0] FN_AND    = 4'b0111;
  localparam logic [3:0] FN_PASS_B = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU; shifts use the low six bits of b, unknown codes give zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int FUNC_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [FUNC_W-1:0] func,
  output logic [DATA_W-1:0] y
);

  logic [5:0] shamt;

  assign shamt = b[5:0];

  always_comb begin
    y = '0;
    case (func)
      FUNC_W'(FN_ADD):    y = a + b;
      FUNC_W'(FN_SUB):    y = a - b;
      FUNC_W'(FN_SLL):    y = a << shamt;
      FUNC_W'(FN_SLT):    y = DATA_W'($signed(a) < $signed(b));
      FUNC_W'(FN_SLTU):   y = DATA_W'(a < b);
      FUNC_W'(FN_XOR):    y = a ^ b;
      FUNC_W'(FN_SRL):    y = a >> shamt;
      FUNC_W'(FN_SRA):    y = $signed(a) >>> shamt;
      FUNC_W'(FN_OR):     y = a | b;
      FUNC_W'(FN_AND):    y = a & b;
      FUNC_W'(FN_PASS_B): y = b;
      default:            y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation in flight.
// Flow is IDLE -> EXEC -> RESP; a new request may be taken in the RESP handshake cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data
);

  state_t            state;
  logic              owner;
  logic              lastGrant;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [FUNC_W-1:0] opFunc;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] aluOut;
  logic              ownerReady;
  logic              canAccept;
  logic              grant0;
  logic              grant1;
  logic              accept;

  alu_arbiter_alu #(
    .DATA_W(DATA_W),
    .FUNC_W(FUNC_W)
  ) u_alu (
    .a   (opA),
    .b   (opB),
    .func(opFunc),
    .y   (aluOut)
  );

  // Requester 0 wins unless requester 1 is also asking and 0 had the last grant.
  always_comb begin
    ownerReady = owner ? rsp1_ready : rsp0_ready;
    canAccept  = !rst && ((state == ST_IDLE) || ((state == ST_RESP) && ownerReady));
    grant0     = req0_valid && (!req1_valid || lastGrant);
    grant1     = req1_valid && !grant0;
    req0_ready = canAccept && grant0;
    req1_ready = canAccept && grant1;
    accept     = req0_ready || req1_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      lastGrant  <= 1'b1;
      opA        <= '0;
      opB        <= '0;
      opFunc     <= '0;
      result     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      if (accept) begin
        opA       <= grant1 ? req1_a : req0_a;
        opB       <= grant1 ? req1_b : req0_b;
        opFunc    <= grant1 ? req1_func : req0_func;
        owner     <= grant1;
        lastGrant <= grant1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_EXEC;
        end
        ST_EXEC: begin
          result     <= aluOut;
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (ownerReady) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_data = result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a table of single operations plus hand-written
// sequences for contention, backpressure, back-to-back issue and mid-operation reset.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic        who;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  func;
    logic [63:0] expected;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_func, req1_func;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [63:0] rsp_data;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[15];

  alu_arbiter #(
    .DATA_W(64),
    .FUNC_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_func (req0_func),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_func (req1_func),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence never returns.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic who, input logic valid, input logic [63:0] a,
                               input logic [63:0] b, input logic [3:0] f);
    if (who) begin
      req1_valid = valid; req1_a = a; req1_b = b; req1_func = f;
    end else begin
      req0_valid = valid; req0_a = a; req0_b = b; req0_func = f;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
    end
  endtask

  // One isolated operation with ready consumers; checks acceptance, latency and data.
  task automatic runOp(input logic who, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] f, input logic [63:0] expected, input string tag);
    logic got;
    got = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(who, 1'b1, a, b, f);
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      got = who ? req1_ready : req0_ready;
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, " accept"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    applyStimulus(who, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput({tag, " exec valid"}, 64'(who ? rsp1_valid : rsp0_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    checkOutput({tag, " rsp valid"}, 64'(who ? rsp1_valid : rsp0_valid), 64'd1);
    checkOutput({tag, " other valid"}, 64'(who ? rsp0_valid : rsp1_valid), 64'd0);
    checkOutput({tag, " data"}, rsp_data, expected);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 64'd5, 64'd3, FN_ADD, 64'd8};
    vecs[1]  = '{1'b1, 64'd3, 64'd5, FN_SUB, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2]  = '{1'b0, 64'd1, 64'h41, FN_SLL, 64'd2};
    vecs[3]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, FN_SLT, 64'd1};
    vecs[4]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, FN_SLTU, 64'd0};
    vecs[5]  = '{1'b1, 64'hF0F0, 64'h0FF0, FN_XOR, 64'hFF00};
    vecs[6]  = '{1'b0, 64'h80, 64'd4, FN_SRL, 64'd8};
    vecs[7]  = '{1'b1, 64'h8000_0000_0000_0000, 64'd63, FN_SRA, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8]  = '{1'b0, 64'hA0, 64'h05, FN_OR, 64'hA5};
    vecs[9]  = '{1'b1, 64'hF0F0, 64'h3C3C, FN_AND, 64'h3030};
    vecs[10] = '{1'b0, 64'd123, 64'hDEAD_BEEF, FN_PASS_B, 64'hDEAD_BEEF};
    vecs[11] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, FN_ADD, 64'd0};
    vecs[12] = '{1'b0, 64'd7, 64'd9, 4'b1111, 64'd0};
    vecs[13] = '{1'b1, 64'h4000_0000_0000_0000, 64'd2, FN_SRA, 64'h1000_0000_0000_0000};
    vecs[14] = '{1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, FN_SLT, 64'd0};

    rst = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 64'd1, 64'd1, FN_ADD);
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req0_ready", 64'(req0_ready), 64'd0);
    checkOutput("reset rsp0_valid", 64'(rsp0_valid), 64'd0);
    checkOutput("reset rsp1_valid", 64'(rsp1_valid), 64'd0);
    checkOutput("reset rsp_data", rsp_data, 64'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] contention after reset");
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 64'd10, 64'd4, FN_SUB);
    applyStimulus(1'b1, 1'b1, 64'd1, 64'd2, FN_SLTU);
    @(negedge clk);
    checkOutput("contend req0_ready", 64'(req0_ready), 64'd1);
    checkOutput("contend req1_ready", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("contend exec req1_ready", 64'(req1_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("contend rsp0_valid", 64'(rsp0_valid), 64'd1);
    checkOutput("contend rsp1_valid", 64'(rsp1_valid), 64'd0);
    checkOutput("contend data0", rsp_data, 64'd6);
    checkOutput("contend req1 taken on handshake", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("contend rsp0 dropped", 64'(rsp0_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("contend rsp1_valid", 64'(rsp1_valid), 64'd1);
    checkOutput("contend data1", rsp_data, 64'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 64'd2, 64'd2, FN_ADD);
    applyStimulus(1'b1, 1'b1, 64'd3, 64'd3, FN_ADD);
    @(negedge clk);
    checkOutput("second contend req0_ready", 64'(req0_ready), 64'd1);
    checkOutput("second contend req1_ready", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    @(posedge clk); @(negedge clk);
    checkOutput("second contend data", rsp_data, 64'd4);
    @(posedge clk); #1;

    $display("[TB] backpressure on requester 1");
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 64'hFF, 64'h0F, FN_XOR);
    @(negedge clk);
    checkOutput("bp req1_ready", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b1, 64'd1, 64'd1, FN_ADD);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d rsp1_valid", i), 64'(rsp1_valid), 64'd1);
      checkOutput($sformatf("bp%0d data", i), rsp_data, 64'hF0);
      checkOutput($sformatf("bp%0d req0_ready", i), 64'(req0_ready), 64'd0);
      checkOutput($sformatf("bp%0d req1_ready", i), 64'(req1_ready), 64'd0);
      checkOutput($sformatf("bp%0d rsp0_valid", i), 64'(rsp0_valid), 64'd0);
      @(posedge clk);
    end
    #1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp release req0_ready", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("bp release rsp1 dropped", 64'(rsp1_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("bp follow-on rsp0_valid", 64'(rsp0_valid), 64'd1);
    checkOutput("bp follow-on data", rsp_data, 64'd2);
    @(posedge clk); #1;

    $display("[TB] back-to-back on requester 0");
    rsp0_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 64'd1, 64'd1, FN_ADD);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b%0d req0_ready", i), 64'(req0_ready), 64'(i % 2 == 0));
      checkOutput($sformatf("b2b%0d rsp0_valid", i), 64'(rsp0_valid), 64'(i % 2 == 0 && i > 0));
      if (i % 2 == 0 && i > 0)
        checkOutput($sformatf("b2b%0d data", i), rsp_data, 64'(2 * (i / 2)));
      @(posedge clk); #1;
      if (i % 2 == 0)
        applyStimulus(1'b0, 1'b1, 64'(i / 2 + 2), 64'(i / 2 + 2), FN_ADD);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); @(negedge clk);
    checkOutput("b2b last rsp0_valid", 64'(rsp0_valid), 64'd1);
    checkOutput("b2b last data", rsp_data, 64'd10);
    @(posedge clk); #1;

    $display("[TB] reset during EXEC");
    applyStimulus(1'b0, 1'b1, 64'd5, 64'd3, FN_ADD);
    @(negedge clk);
    checkOutput("rst-exec accept", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    #1;
    checkOutput("rst-exec rsp0_valid", 64'(rsp0_valid), 64'd0);
    checkOutput("rst-exec rsp1_valid", 64'(rsp1_valid), 64'd0);
    checkOutput("rst-exec rsp_data", rsp_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post-rst%0d rsp0_valid", i), 64'(rsp0_valid), 64'd0);
      checkOutput($sformatf("post-rst%0d rsp1_valid", i), 64'(rsp1_valid), 64'd0);
    end
    @(posedge clk); #1;

    $display("[TB] vector table");
    for (int i = 0; i < 15; i++)
      runOp(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].func, vecs[i].expected,
            $sformatf("vec%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
